acc_exec_stage: RTL
===================

Name: acc_exec_stage

Overview:
- Parametrised second (execute) stage of the accumulator processor.
- Accepts one decoded instruction per transaction from the fetch/decode stage over a valid/ready handshake, then executes it on the accumulator and updates the carry/zero/overflow flags.
- Returns the next PC and a completion pulse to stage 1.
- Adds features the previous stage lacked: a configurable data width, a return-address stack for nested interrupts, an interrupt enable, and a HALT state.

Parameters:
- DATA_W, 8: accumulator, operand and flag-arithmetic width.
- PC_W, 8: program counter width.
- RSTACK_DEPTH, 4: return-address stack entries (≥1).
- IRQ_VECTOR, 'hF0: PC loaded on interrupt entry (PC_W bits).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  stage 1 presents an instruction.
- in_ready  out  1  stage accepts an instruction this cycle.
- in_opcode  in  5  operation code.
- in_operand  in  DATA_W  effective operand, already resolved by stage 1.
- in_pc  in  PC_W  PC of the instruction.
- irq  in  1  level-sensitive interrupt request.
- acc_out  out  DATA_W  accumulator.
- cout_out, zero_out, ovf_out  out  1 each  flag registers.
- next_pc  out  PC_W  PC for stage 1; valid when done=1.
- done  out  1  one-cycle completion pulse.
- halted  out  1  core is in HALT.
- rstack_err  out  1  sticky flag: RETI executed with an empty stack.

Behaviour:
- Reset values:
  - acc_out=0; all flags=0; next_pc=0; done=0; halted=0; rstack_err=0.
  - Stack pointer=0; interrupt enable (IE)=1.
  - State=IDLE; in_ready=1.
- FSM states: IDLE, EXEC, DONE, HALT.
  - IDLE: in_ready=1. On in_valid, latch opcode, operand and pc, then go to EXEC.
  - EXEC: in_ready=0. Compute and register the results, then go to DONE (or HALT for the HALT opcode).
  - DONE: done=1 for exactly one cycle with next_pc valid, then return to IDLE.
  - Latency: the accept edge to the done-high cycle is 2 cycles. Maximum throughput is one instruction per 3 cycles.
- Opcodes (5 bits):
  - 00000 NOP.
  - 00001 LDA: acc=op; update Z only.
  - 00010 ADD: {C,acc}=acc+op; V=signed overflow.
  - 00011 SUB: acc=acc-op; C=borrow (acc<op unsigned); V=signed overflow.
  - 00100 AND, 00101 OR, 00110 XOR, 00111 NOT (acc=~acc): V=0; C unchanged.
  - 01000 SHL: C=old msb; V=0.
  - 01001 SHR: logical; C=old lsb; V=0.
  - 01010 JMP: next_pc=op[PC_W-1:0].
  - 01011 JZ: jump if Z=1.
  - 01100 JC: jump if C=1.
  - 01101 RETI: pop the stack into next_pc; IE=1.
  - 01110 EI: IE=1.
  - 01111 DI: IE=0.
  - 10000 HALT.
  - Undefined opcodes execute as NOP.
- Z is updated by every ALU/LDA op and equals (acc_result==0). Jumps leave all flags unchanged.
- Default next_pc = in_pc+1, wrapping modulo 2^PC_W.
- Interrupt entry:
  - Conditions: in EXEC, irq=1, IE=1, and stack not full.
  - Action: push the computed next_pc, force next_pc=IRQ_VECTOR, and set IE=0 in the same cycle.
  - If the stack is full, the irq is ignored until a RETI frees a slot.
  - RETI followed by an immediately pending irq is allowed (re-entry). The push takes the popped value.
- RETI with an empty stack: next_pc=in_pc+1; set rstack_err; IE=1.
- HALT:
  - halted=1, in_ready=0, no done pulse.
  - Exit when irq=1 and IE=1: push in_pc+1, pulse done with next_pc=IRQ_VECTOR (via DONE), then clear halted.
  - If IE=0 or the stack is full, leave only by reset.
- If in_valid is held across DONE, the next instruction is accepted only in IDLE. No acceptance occurs in DONE.
- Reset mid-operation: the in-flight instruction is discarded and no done pulse is issued.

Optional Feature:
- Macro: ACC_EXEC_MUL_EN.
- Defined: opcode 10001 MUL. acc=low DATA_W bits of acc*op. C=1 if the high half is nonzero. V=0. Z is updated. Latency is unchanged (single-cycle combinational multiply in EXEC).
- Undefined: 10001 executes as NOP.

Decomposition:
- Package acc_pkg holds:
  - opcode localparams (OP_NOP … OP_MUL);
  - the FSM state enum;
  - default width constants.
- Sub-module acc_rstack (parametrised LIFO of PC_W×RSTACK_DEPTH):
  - inputs: push, pop, din;
  - outputs: dout, full, empty;
  - push and pop together → pop then push, net occupancy unchanged.

Test Plan:
- Reset, then LDA 8'h7F, ADD 8'h01 → acc=80, V=1, C=0, Z=0; done 2 cycles after each accept; next_pc=in_pc+1.
- LDA FF, ADD 01 → acc=00, C=1, Z=1. Then JC 3C at pc=10 → next_pc=3C. Then SUB 01 (acc=00) → acc=FF, C=1.
- irq=1 during ADD at pc=20 → next_pc=F0, IE=0. RETI → next_pc=21, IE=1.
- Five nested interrupts with RSTACK_DEPTH=4 → the 5th is ignored while full. RETI on empty → next_pc=pc+1, rstack_err=1.
- HALT at pc=40 → halted=1, in_ready=0. Then irq=1 → done with next_pc=F0. RETI → 41.
- Undefined opcode 10101 → NOP, flags unchanged. With ACC_EXEC_MUL_EN, acc=10 MUL 20 → acc=00, C=1, Z=1.

Source files
------------

// File: rtl/acc_pkg.sv
// ----------------------------------------------------------------------------
// acc_pkg
// Shared constants for the accumulator execute stage:
//   - default width constants
//   - 5-bit opcode encodings (OP_NOP .. OP_MUL)
//   - execute-stage FSM state type
// No ports (package).
// ----------------------------------------------------------------------------
package acc_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int PC_W_DEF         = 8;
  localparam int RSTACK_DEPTH_DEF = 4;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_LDA  = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_NOT  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_JMP  = 5'b01010;
  localparam logic [4:0] OP_JZ   = 5'b01011;
  localparam logic [4:0] OP_JC   = 5'b01100;
  localparam logic [4:0] OP_RETI = 5'b01101;
  localparam logic [4:0] OP_EI   = 5'b01110;
  localparam logic [4:0] OP_DI   = 5'b01111;
  localparam logic [4:0] OP_HALT = 5'b10000;
  localparam logic [4:0] OP_MUL  = 5'b10001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/acc_rstack.sv
// ----------------------------------------------------------------------------
// acc_rstack
// Return-address LIFO, PC_W bits x DEPTH entries.
// Ports:
//   clk, reset      clock, async active-high reset
//   push, pop       stack operations; both together = pop then push
//   din             value pushed
//   dout            current top of stack (0 when empty)
//   full, empty     occupancy status
// Pops on an empty stack and pushes on a full stack (without a pop) are
// ignored.
// ----------------------------------------------------------------------------
module acc_rstack #(
  parameter int PC_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [PC_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [IDX_W-1:0] top_idx, wr_idx;
  logic             do_pop, do_push;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == PTR_W'(DEPTH));
  assign top_idx = IDX_W'(sp_q - PTR_W'(1));
  assign dout    = empty ? '0 : mem_q[top_idx];

  always_comb begin
    do_pop  = pop && !empty;
    // a simultaneous pop frees the slot the push needs
    do_push = push && (!full || do_pop);
    wr_idx  = do_pop ? top_idx : IDX_W'(sp_q);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_idx] = din;
    sp_d = sp_q;
    if (do_pop && !do_push)      sp_d = sp_q - PTR_W'(1);
    else if (do_push && !do_pop) sp_d = sp_q + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/acc_exec_stage.sv
// ----------------------------------------------------------------------------
// acc_exec_stage
// Execute stage of the accumulator processor. Takes one decoded instruction
// per valid/ready handshake, executes it on the accumulator, updates C/Z/V,
// and returns next_pc with a one-cycle done pulse. Supports nested
// interrupts through a return-address stack, an interrupt enable and HALT.
// Optional feature macro: ACC_EXEC_MUL_EN (opcode 10001 = MUL; otherwise NOP).
// Ports:
//   clk, reset                 clock, async active-high reset
//   in_valid / in_ready        instruction handshake
//   in_opcode, in_operand      decoded instruction, resolved operand
//   in_pc                      PC of the instruction
//   irq                        level-sensitive interrupt request
//   acc_out                    accumulator
//   cout_out, zero_out, ovf_out flags
//   next_pc, done              next PC, valid during the done pulse
//   halted                     core is in HALT
//   rstack_err                 sticky: RETI with empty stack
//
// state | meaning
// IDLE  | ready; latch instruction on in_valid
// EXEC  | compute and register results, handle interrupt entry
// DONE  | done=1 for one cycle, next_pc valid
// HALT  | stopped; leave on irq with IE=1 and stack space
// ----------------------------------------------------------------------------
module acc_exec_stage
  import acc_pkg::*;
#(
  parameter int              DATA_W       = DATA_W_DEF,
  parameter int              PC_W         = PC_W_DEF,
  parameter int              RSTACK_DEPTH = RSTACK_DEPTH_DEF,
  parameter logic [PC_W-1:0] IRQ_VECTOR   = 'hF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [DATA_W-1:0] in_operand,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              irq,
  output logic [DATA_W-1:0] acc_out,
  output logic              cout_out,
  output logic              zero_out,
  output logic              ovf_out,
  output logic [PC_W-1:0]   next_pc,
  output logic              done,
  output logic              halted,
  output logic              rstack_err
);

  localparam int MSB = DATA_W - 1;

  state_t            state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              c_q, c_d, z_q, z_d, v_q, v_d;
  logic [PC_W-1:0]   next_pc_q, next_pc_d;
  logic              ie_q, ie_d;
  logic              rstack_err_q, rstack_err_d;

  logic              rs_push, rs_pop, rs_full, rs_empty;
  logic [PC_W-1:0]   rs_din, rs_dout;

  logic [PC_W-1:0]   pc_inc, npc;
  logic              ie_n, alu_wr;
  logic [DATA_W-1:0] alu_res, diff;
  logic [DATA_W:0]   sum;
`ifdef ACC_EXEC_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  acc_rstack #(.PC_W(PC_W), .DEPTH(RSTACK_DEPTH)) u_rstack (
    .clk   (clk),
    .reset (reset),
    .push  (rs_push),
    .pop   (rs_pop),
    .din   (rs_din),
    .dout  (rs_dout),
    .full  (rs_full),
    .empty (rs_empty)
  );

  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    operand_d    = operand_q;
    pc_d         = pc_q;
    acc_d        = acc_q;
    c_d          = c_q;
    z_d          = z_q;
    v_d          = v_q;
    next_pc_d    = next_pc_q;
    ie_d         = ie_q;
    rstack_err_d = rstack_err_q;
    rs_push      = 1'b0;
    rs_pop       = 1'b0;
    rs_din       = pc_inc;
    npc          = pc_inc;
    ie_n         = ie_q;
    alu_wr       = 1'b0;
    alu_res      = acc_q;
    sum          = {1'b0, acc_q} + {1'b0, operand_q};
    diff         = acc_q - operand_q;
`ifdef ACC_EXEC_MUL_EN
    prod         = (2*DATA_W)'(acc_q) * (2*DATA_W)'(operand_q);
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d      = in_opcode;
          operand_d = in_operand;
          pc_d      = in_pc;
          state_d   = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = (op_q == OP_HALT) ? ST_HALT : ST_DONE;
        case (op_q)
          OP_LDA:  begin alu_wr = 1'b1; alu_res = operand_q; end
          OP_ADD: begin
            alu_wr  = 1'b1;
            alu_res = sum[MSB:0];
            c_d     = sum[DATA_W];
            v_d     = (acc_q[MSB] == operand_q[MSB]) && (sum[MSB] != acc_q[MSB]);
          end
          OP_SUB: begin
            alu_wr  = 1'b1;
            alu_res = diff;
            c_d     = (acc_q < operand_q);
            v_d     = (acc_q[MSB] != operand_q[MSB]) && (diff[MSB] != acc_q[MSB]);
          end
          OP_AND:  begin alu_wr = 1'b1; alu_res = acc_q & operand_q; v_d = 1'b0; end
          OP_OR:   begin alu_wr = 1'b1; alu_res = acc_q | operand_q; v_d = 1'b0; end
          OP_XOR:  begin alu_wr = 1'b1; alu_res = acc_q ^ operand_q; v_d = 1'b0; end
          OP_NOT:  begin alu_wr = 1'b1; alu_res = ~acc_q;            v_d = 1'b0; end
          OP_SHL:  begin alu_wr = 1'b1; alu_res = acc_q << 1; c_d = acc_q[MSB]; v_d = 1'b0; end
          OP_SHR:  begin alu_wr = 1'b1; alu_res = acc_q >> 1; c_d = acc_q[0];   v_d = 1'b0; end
          OP_JMP:  npc = PC_W'(operand_q);
          OP_JZ:   if (z_q) npc = PC_W'(operand_q);
          OP_JC:   if (c_q) npc = PC_W'(operand_q);
          OP_RETI: begin
            ie_n = 1'b1;
            if (!rs_empty) begin
              rs_pop = 1'b1;
              npc    = rs_dout;
            end else begin
              rstack_err_d = 1'b1;
            end
          end
          OP_EI:   ie_n = 1'b1;
          OP_DI:   ie_n = 1'b0;
`ifdef ACC_EXEC_MUL_EN
          OP_MUL: begin
            alu_wr  = 1'b1;
            alu_res = prod[DATA_W-1:0];
            c_d     = |prod[2*DATA_W-1:DATA_W];
            v_d     = 1'b0;
          end
`endif
          default: ;
        endcase
        if (alu_wr) begin
          acc_d = alu_res;
          z_d   = (alu_res == '0);
        end
        // Interrupt entry uses the IE value the instruction leaves behind, so
        // RETI can re-enter at once (its pop frees the slot for the push) and
        // DI blocks the irq in its own cycle.
        if (op_q != OP_HALT && irq && ie_n && (!rs_full || rs_pop)) begin
          rs_push = 1'b1;
          rs_din  = npc;
          npc     = IRQ_VECTOR;
          ie_n    = 1'b0;
        end
        next_pc_d = npc;
        ie_d      = ie_n;
      end

      ST_DONE: state_d = ST_IDLE;

      ST_HALT: begin
        if (irq && ie_q && !rs_full) begin
          rs_push   = 1'b1;
          rs_din    = pc_inc;
          next_pc_d = IRQ_VECTOR;
          ie_d      = 1'b0;
          state_d   = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_NOP;
      operand_q    <= '0;
      pc_q         <= '0;
      acc_q        <= '0;
      c_q          <= 1'b0;
      z_q          <= 1'b0;
      v_q          <= 1'b0;
      next_pc_q    <= '0;
      ie_q         <= 1'b1;
      rstack_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      operand_q    <= operand_d;
      pc_q         <= pc_d;
      acc_q        <= acc_d;
      c_q          <= c_d;
      z_q          <= z_d;
      v_q          <= v_d;
      next_pc_q    <= next_pc_d;
      ie_q         <= ie_d;
      rstack_err_q <= rstack_err_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign halted     = (state_q == ST_HALT);
  assign acc_out    = acc_q;
  assign cout_out   = c_q;
  assign zero_out   = z_q;
  assign ovf_out    = v_q;
  assign next_pc    = next_pc_q;
  assign rstack_err = rstack_err_q;

endmodule
